// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding-mux selects and
// multi-cycle execute FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mc_state_t;

  localparam int unsigned STALL_CNT_W = 32;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side bundle of the hazard controller: register addresses and stage
// controls in, forwarding selects, stall/flush and multi-cycle status out.
interface hazard_controller_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MC_LEN_WIDTH   = 6
);
  logic [REG_ADDR_WIDTH-1:0] Rs1D, Rs2D;
  logic [REG_ADDR_WIDTH-1:0] Rs1E, Rs2E, RdE;
  logic [REG_ADDR_WIDTH-1:0] RdM, RdW;
  logic                      RegWriteM, RegWriteW;
  logic                      LoadE, PCSrcE, MultiCycleE;
  logic [MC_LEN_WIDTH-1:0]   McLenE;

  logic [1:0]                ForwardAE, ForwardBE;
  logic                      StallF, StallD, StallE;
  logic                      FlushD, FlushE, FlushM;
  logic                      McStart, McBusy, McDone;
  logic [31:0]               StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, MultiCycleE, McLenE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, McStart, McBusy, McDone, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, MultiCycleE, McLenE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, McStart, McBusy, McDone, StallCount
  );
endinterface

// File: rtl/hazard_controller_forward_select.sv
// Operand forwarding select for one Execute source register; the Memory stage
// wins over Writeback because it holds the younger result.
module forward_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
  input  logic                      reg_write_m_i,
  input  logic                      reg_write_w_i,
  output fwd_sel_t                  fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
      fwd_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller: forwarding, load-use stall, branch flush and a counted
// multi-cycle execute sequencer with a saturating stall-cycle counter.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MC_LEN_WIDTH   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_controller_if.slave hz
);

  fwd_sel_t                 fwd_a, fwd_b;
  mc_state_t                state_q, state_d;
  logic [MC_LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [MC_LEN_WIDTH-1:0]  len_eff;
  logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                     lw_stall, mc_start, mc_busy, mc_done, mc_stall, stall_fd;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == '1) ? v : v + STALL_CNT_W'(1);
  endfunction

  forward_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_i          (hz.Rs1E),
    .rd_m_i        (hz.RdM),
    .rd_w_i        (hz.RdW),
    .reg_write_m_i (hz.RegWriteM),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_o         (fwd_a)
  );

  forward_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_i          (hz.Rs2E),
    .rd_m_i        (hz.RdM),
    .rd_w_i        (hz.RdW),
    .reg_write_m_i (hz.RegWriteM),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_o         (fwd_b)
  );

  always_comb begin
    lw_stall = hz.LoadE && (hz.RdE != '0) &&
               ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    // A zero latency is treated as a single-cycle op.
    len_eff  = (hz.McLenE == '0) ? MC_LEN_WIDTH'(1) : hz.McLenE;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_start = 1'b0;
    mc_busy  = 1'b0;
    mc_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hz.MultiCycleE && !hz.PCSrcE) begin
          mc_start = 1'b1;
          mc_busy  = 1'b1;
          cnt_d    = len_eff - MC_LEN_WIDTH'(1);
          state_d  = (len_eff == MC_LEN_WIDTH'(1)) ? DONE : BUSY;
        end
      end
      BUSY: begin
        mc_busy = 1'b1;
        if (cnt_q == MC_LEN_WIDTH'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - MC_LEN_WIDTH'(1);
        end
      end
      DONE: begin
        mc_done = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    mc_stall    = mc_start || (state_q == BUSY);
    stall_fd    = lw_stall || mc_stall;
    stall_cnt_d = stall_fd ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset holds every combinational control quiet, independent of the inputs.
  always_comb begin
    hz.ForwardAE  = rst_n ? fwd_a : FWD_RF;
    hz.ForwardBE  = rst_n ? fwd_b : FWD_RF;
    hz.StallF     = rst_n && stall_fd;
    hz.StallD     = rst_n && stall_fd;
    hz.StallE     = rst_n && mc_stall;
    hz.FlushM     = rst_n && mc_stall;
    hz.FlushD     = rst_n && hz.PCSrcE && !mc_stall;
    hz.FlushE     = rst_n && (lw_stall || hz.PCSrcE) && !mc_stall;
    hz.McStart    = rst_n && mc_start;
    hz.McBusy     = rst_n && mc_busy;
    hz.McDone     = rst_n && mc_done;
    hz.StallCount = stall_cnt_q;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, register-address width.
REQ-002 SHALL have parameter MC_LEN_WIDTH, default 6, width of the multi-cycle latency field.
REQ-003 SHALL have one clock, clk, and reset rst_n, which is asynchronous and active-low.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- Rs1D, Rs2D  in  REG_ADDR_WIDTH  source registers in Decode.
- Rs1E, Rs2E, RdE  in  REG_ADDR_WIDTH  sources and destination in Execute.
- RdM, RdW  in  REG_ADDR_WIDTH  destinations in Memory and Writeback.
- RegWriteM, RegWriteW  in  1  write enables in Memory and Writeback.
- LoadE  in  1  Execute instruction is a load.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- MultiCycleE  in  1  Execute instruction is a multi-cycle ALU op.
- McLenE  in  MC_LEN_WIDTH  latency of that op, in cycles.
- ForwardAE, ForwardBE  out  2  operand-mux selects.
- StallF, StallD, StallE  out  1  hold the fetch, decode and execute registers.
- FlushD, FlushE, FlushM  out  1  bubble the decode, execute and memory registers.
- McStart  out  1  one-cycle start pulse to the multi-cycle unit.
- McBusy  out  1  a multi-cycle op is in progress.
- McDone  out  1  result valid; Execute advances this cycle.
- StallCount  out  32  performance counter of stalled cycles.

Function
REQ-005 Forward select encoding SHALL be: 00 = register file, 01 = ResultW, 10 = ALUResultM; 11 SHALL never be driven.
REQ-006 ForwardAE SHALL be 10 if RegWriteM, RdM!=0 and RdM==Rs1E; else 01 if RegWriteW, RdW!=0 and RdW==Rs1E; else 00. Memory has priority when both stages match.
REQ-007 ForwardBE SHALL follow REQ-006 with Rs2E in place of Rs1E.
REQ-008 lwStall SHALL be asserted when LoadE, RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-009 The FSM SHALL have three states: IDLE, BUSY and DONE. Register cnt SHALL be MC_LEN_WIDTH bits wide.
REQ-010 Start condition: in IDLE with MultiCycleE=1 and PCSrcE=0.
- McStart=1, stall asserted, cnt loads Leff-1, where Leff = max(McLenE, 1).
- Next state is DONE if Leff==1, otherwise BUSY.
REQ-011 In BUSY: stall asserted and McBusy=1. If cnt==1 the next state is DONE; otherwise cnt decrements.
REQ-012 In DONE: McDone=1, no multi-cycle stall, next state is IDLE. A start SHALL NOT be taken in DONE.
REQ-013 A multi-cycle op with latency L SHALL hold Execute for exactly L stalled cycles, and McDone SHALL occur on cycle L+1.
REQ-014 mcStall SHALL be the combinational start condition, or state==BUSY.
REQ-015 Stall and flush equations:
- StallF = StallD = lwStall | mcStall.
- StallE = mcStall.
- FlushM = mcStall.
- FlushD = PCSrcE & !mcStall.
- FlushE = (lwStall | PCSrcE) & !mcStall.
REQ-016 McBusy SHALL be 1 in the start cycle and in every BUSY cycle.
REQ-017 StallCount SHALL increment on every cycle with StallF=1 and SHALL saturate at 0xFFFFFFFF.
REQ-018 All outputs other than the FSM state, cnt and StallCount SHALL be combinational.

Reset
REQ-019 Asserting rst_n=0 SHALL immediately force state IDLE, cnt=0 and StallCount=0, including when asserted mid-operation.
REQ-020 While rst_n=0, all stall, flush and Mc* outputs SHALL be 0 and both forward selects SHALL be 00.
REQ-021 After release, an in-flight op SHALL NOT resume. A start SHALL occur only if MultiCycleE is still asserted in IDLE.

Structure
REQ-022 Shared package hazard_pkg SHALL hold the fwd_sel_t enum (FWD_RF, FWD_W, FWD_M) and the mc_state_t enum (IDLE, BUSY, DONE).
REQ-023 Sub-module forward_select (combinational, instantiated twice) SHALL implement REQ-006 for one operand.

Verification
REQ-024 RdM=5 with RegWriteM=1, RdW=5 with RegWriteW=1, Rs1E=5 -> ForwardAE=10. Same with RdM=0 -> ForwardAE=01.
REQ-025 LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. Same with RdE=0 -> no stall.
REQ-026 MultiCycleE=1, McLenE=4 -> McStart on cycle 0, stall on cycles 0–3, McDone on cycle 4, StallCount +4.
REQ-027 McLenE=0 and McLenE=1 -> each gives exactly one stalled cycle, then McDone.
REQ-028 Back-to-back multi-cycle ops with McLenE=2 -> pattern start, BUSY, DONE, start; no restart occurs in DONE.
REQ-029 rst_n pulsed low during BUSY -> all outputs 0 asynchronously; state IDLE on release; StallCount=0.
